// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared types and helpers for the nibble-serial add/sub unit.
//                - state_e     : controller states (IDLE, RUN, DONE)
//                - NIBBLE_W    : width of the shared arithmetic slice
//                - addsub_ovf  : signed overflow from the MSB column values
//  Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The carry into the MSB column is recovered from that column's inputs and
  // sum (a ^ b ^ cin = sum); overflow is that carry differing from the carry out.
  function automatic logic addsub_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic sum_msb,
                                      input logic cout);
    return (a_msb ^ b_msb ^ sum_msb) ^ cout;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_nibble.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_nibble
//  Description : Combinational 4-bit slice: sum = a + b + cin.
//  Ports       : a_i, b_i   [NIBBLE_W-1:0]  operand nibbles (b already inverted
//                                           by the caller for subtraction)
//                cin_i                      carry in
//                sum_o      [NIBBLE_W-1:0]  sum nibble
//                cout_o                     carry out of the top bit
//                c3_o                       carry into the top bit
//  Revision    : 1.0  initial release
// ============================================================================
module addsub_nibble
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o,
  output logic                c3_o
);

  logic [NIBBLE_W:0]   w_full;
  logic [NIBBLE_W-1:0] w_low;

  assign w_full = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};

  // Sum of the lower three columns only; its top bit is the carry into bit 3.
  assign w_low  = {1'b0, a_i[NIBBLE_W-2:0]} + {1'b0, b_i[NIBBLE_W-2:0]}
                + {{(NIBBLE_W-1){1'b0}}, cin_i};

  assign sum_o  = w_full[NIBBLE_W-1:0];
  assign cout_o = w_full[NIBBLE_W];
  assign c3_o   = w_low[NIBBLE_W-1];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_addsub
//  Description : WIDTH-bit two's-complement add/subtract computed one nibble
//                per clock (LSB first) on a single shared 4-bit slice.
//  Ports       : clk, rst_n                 clock, synchronous active-low reset
//                in_valid/in_ready          request handshake
//                in_a, in_b [WIDTH-1:0]     operands
//                in_sub                     0 = A+B, 1 = A-B
//                out_valid/out_ready        result handshake
//                out_res [WIDTH-1:0]        result modulo 2^WIDTH
//                out_cout                   carry out (sub: 1 = no borrow)
//                out_ovf                    signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_c3;

  // Select the operand nibbles addressed by the index.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        w_a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  addsub_nibble u_slice (
    .a_i    (w_a_nib),
    .b_i    (w_b_nib),
    .cin_i  (carry_q),
    .sum_o  (w_sum),
    .cout_o (w_cout),
    .c3_o   (w_c3)
  );

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          // Subtraction is A + ~B + 1: invert here, seed the carry with 1.
          b_d     = in_b ^ {WIDTH{in_sub}};
          carry_d = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDX_W'(i)) begin
            res_d[i*NIBBLE_W +: NIBBLE_W] = w_sum;
          end
        end
        carry_d = w_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = w_cout;
          ovf_d   = addsub_ovf(w_a_nib[NIBBLE_W-1], w_b_nib[NIBBLE_W-1],
                               w_sum[NIBBLE_W-1], w_cout);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // The slice's own carry into bit 3 must agree with the value the overflow
  // helper reconstructs from the MSB column.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == RUN) begin
      assert (w_c3 == (w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1] ^ w_sum[NIBBLE_W-1]));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_addsub
//  Description : Self-checking bench. A 16-bit instance runs a vector table
//                and hand-written corner sequences; 8- and 32-bit instances
//                run random operations against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic done8  = 1'b0;
  logic done32 = 1'b0;

  // ---------------- 16-bit instance ----------------
  logic        rst_n, in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] in_a, in_b, out_res;
  exp_t        sb16[$];

  nibble_serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // ---------------- 8-bit instance ----------------
  logic        rst8_n, v8, rdy8, s8, ov8, or8, c8, f8;
  logic [7:0]  a8, b8, res8;
  exp_t        sb8[$];

  nibble_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8), .in_sub(s8), .out_valid(ov8),
    .out_ready(or8), .out_res(res8), .out_cout(c8), .out_ovf(f8)
  );

  // ---------------- 32-bit instance ----------------
  logic        rst32_n, v32, rdy32, s32, ov32, or32, c32, f32;
  logic [31:0] a32, b32, res32;
  exp_t        sb32[$];

  nibble_serial_addsub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst32_n), .in_valid(v32), .in_ready(rdy32),
    .in_a(a32), .in_b(b32), .in_sub(s32), .out_valid(ov32),
    .out_ready(or32), .out_res(res32), .out_cout(c32), .out_ovf(f32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference: plain integer arithmetic on w-bit values, signed overflow from
  // the range of the exact signed result.
  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub);
    exp_t   e;
    longint m, ua, ub, full, sa, sb, r;
    m    = longint'(1) << w;
    ua   = longint'({32'd0, a}) % m;
    ub   = longint'({32'd0, b}) % m;
    full = sub ? (ua - ub) : (ua + ub);
    e.cout = sub ? (ua >= ub) : (full >= m);
    e.res  = 32'(((full % m) + m) % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sub ? (sa - sb) : (sa + sb);
    e.ovf = (r >= m / 2) || (r < -(m / 2));
    return e;
  endfunction

  // One complete 16-bit transaction with immediate consumption.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input exp_t e, input string name);
    int   cyc;
    exp_t x;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    check({name, " in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb16.push_back(e);
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check({name, " latency"}, 64'(cyc), 64'(4));
    x = sb16.pop_front();
    check({name, " result"}, 64'({out_res, out_cout, out_ovf}),
          64'({x.res[15:0], x.cout, x.ovf}));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // ---------------- main sequence (16-bit) ----------------
  initial begin
    vec_t tbl [8];
    exp_t x;
    int   cyc;
    logic seen;

    tbl[0] = '{16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("reset outputs", 64'({out_valid, out_res, out_cout, out_ovf}), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      run16(tbl[i].a, tbl[i].b, tbl[i].sub,
            '{{16'd0, tbl[i].res}, tbl[i].cout, tbl[i].ovf}, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      run16(ra, rb, rs, model(16, {16'd0, ra}, {16'd0, rb}, rs), $sformatf("rnd16_%0d", i));
    end

    // Backpressure: result held while out_ready is low, new requests ignored.
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb16.push_back('{32'h3333, 1'b0, 1'b0});
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("bp latency", 64'(cyc), 64'(4));
    x = sb16.pop_front();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp hold%0d", i),
            64'({out_valid, in_ready, out_res, out_cout, out_ovf}),
            64'({1'b1, 1'b0, x.res[15:0], x.cout, x.ovf}));
      in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b1; in_valid = 1'b1;
      if (i < 5) begin @(posedge clk); #1; end
    end
    // Release: DONE->IDLE on this edge, the pending request is taken on the next.
    out_ready = 1'b1;
    in_a = 16'h0100; in_b = 16'h0001; in_sub = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next accepted", 64'(in_ready), 64'(0));
    sb16.push_back('{32'h00FF, 1'b1, 1'b0});
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("bp next latency", 64'(cyc), 64'(4));
    x = sb16.pop_front();
    check("bp next result", 64'({out_res, out_cout, out_ovf}), 64'({x.res[15:0], x.cout, x.ovf}));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // in_valid and operands change during RUN: only the first request counts.
    @(negedge clk);
    in_a = 16'h4321; in_b = 16'h1111; in_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    sb16.push_back('{32'h3210, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
      check($sformatf("run in_ready%0d", i), 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    x = sb16.pop_front();
    check("ignore result", 64'({out_valid, out_res, out_cout, out_ovf}),
          64'({1'b1, x.res[15:0], x.cout, x.ovf}));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Abort with a one-cycle reset pulse during RUN.
    @(negedge clk);
    in_a = 16'h00FF; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("abort outputs", 64'({out_valid, out_res, out_cout, out_ovf}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("abort no valid", 64'(seen), 64'(0));
    check("abort idle", 64'(in_ready), 64'(1));
    run16(16'h00FF, 16'h0001, 1'b0, '{32'h0100, 1'b0, 1'b0}, "after abort");

    // Wait for the width sweeps, bounded by cycle count.
    cyc = 0;
    while (!(done8 && done32) && cyc < 60000) begin @(posedge clk); cyc++; end
    check("sweeps finished", 64'({done8, done32}), 64'(2'b11));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- WIDTH=8 random sweep ----------------
  initial begin
    int   cyc;
    exp_t x;
    rst8_n = 1'b0; v8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst8_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
      sb8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, s8));
      cyc = 0;
      while (!ov8 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("w8 latency", 64'(cyc), 64'(2));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      x = sb8.pop_front();
      check("w8 result", 64'({ov8, res8, c8, f8}), 64'({1'b1, x.res[7:0], x.cout, x.ovf}));
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
    end
    done8 = 1'b1;
  end

  // ---------------- WIDTH=32 random sweep ----------------
  initial begin
    int   cyc;
    exp_t x;
    rst32_n = 1'b0; v32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst32_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; s32 = 1'($urandom); v32 = 1'b1;
      if (n == 0) begin a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; s32 = 1'b0; end
      if (n == 1) begin a32 = 32'h8000_0000; b32 = 32'h0000_0001; s32 = 1'b1; end
      @(posedge clk); #1;
      v32 = 1'b0;
      sb32.push_back(model(32, a32, b32, s32));
      cyc = 0;
      while (!ov32 && cyc < 30) begin @(posedge clk); #1; cyc++; end
      check("w32 latency", 64'(cyc), 64'(8));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      x = sb32.pop_front();
      check("w32 result", 64'({ov32, res32, c32, f32}), 64'({1'b1, x.res, x.cout, x.ovf}));
      @(negedge clk); or32 = 1'b1;
      @(posedge clk); #1; or32 = 1'b0;
    end
    done32 = 1'b1;
  end

  // Hard stop if the bench itself stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running required finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle controller that performs WIDTH-bit two's-complement add or subtract by time-sharing one 4-bit add/sub slice, one nibble per clock, LSB first. The slice's carry is held in a register between nibbles. Sits between a requester (valid/ready in) and a consumer (valid/ready out). It is the area-minimal alternative to a full-width ripple add/sub in the datapath.

## Interface
Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of 4 and ≥ 8.
- NIB, WIDTH/4 (derived, localparam): nibble count and RUN-state length in cycles.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset. Synchronous, active-low.
- in_valid  in  1: request valid.
- in_ready  out  1: request accepted when in_valid && in_ready.
- in_a  in  WIDTH: operand A.
- in_b  in  WIDTH: operand B.
- in_sub  in  1: 0 = A+B, 1 = A−B.
- out_valid  out  1: result valid. Held until accepted.
- out_ready  in  1: consumer accepts when out_valid && out_ready.
- out_res  out  WIDTH: result, modulo 2^WIDTH.
- out_cout  out  1: final carry. For subtract, 1 means no borrow (A ≥ B unsigned).
- out_ovf  out  1: signed overflow.

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On handshake: latch in_a and in_b into op registers. Latch the latched B as in_b XOR {WIDTH{in_sub}}.
  - Set carry register = in_sub, nibble index = 0, then go to RUN.
- RUN:
  - in_ready = 0, and in_valid is ignored.
  - Each cycle: slice computes a_reg[4i+3:4i] + b_reg[4i+3:4i] + carry.
  - The sum nibble is written to res_reg[4i+3:4i]. Carry register ← slice cout. Index increments.
  - Before the last nibble's carry is overwritten, capture the carry into the MSB (from the slice's internal bit-2 carry, or recomputed as a_msb^b_msb^sum_msb) for the overflow calculation.
  - After the nibble with index NIB−1, go to DONE.
- DONE:
  - out_valid = 1.
  - out_res, out_cout and out_ovf are stable and are not modified while out_valid is high.
  - On out_ready go to IDLE.
  - out_ready is never required in IDLE or RUN; its value there is ignored.
- Arithmetic:
  - out_cout = carry out of bit WIDTH−1.
  - out_ovf = carry_into_msb XOR out_cout.
  - Subtract uses the inverted B plus an initial carry of 1.
- Reset mid-operation (any state): the operation is aborted. No out_valid is produced for it, and the next cycle after reset release is IDLE.

## Timing
- Handshake at edge k. Nibble i is computed at edge k+1+i.
- out_valid is high starting in the cycle after edge k+NIB, i.e. NIB cycles after acceptance.
- If out_ready is already high, DONE→IDLE happens at edge k+NIB+1, and the next handshake can occur at edge k+NIB+2. Peak throughput is one operation per NIB+2 cycles.
- Reset values, applied at the first rising edge with rst_n = 0:
  - state = IDLE.
  - out_valid = 0, out_res = 0, out_cout = 0, out_ovf = 0.
- in_ready is combinational from state and rst_n. It is 0 while rst_n = 0.
- out_valid is registered, not combinational from any input.
- No combinational path exists from in_* to out_*.

## Structure
- Shared package addsub_pkg holds:
  - The state enum {IDLE, RUN, DONE}.
  - NIBBLE_W = 4.
  - A function that computes signed overflow from (a_msb, b_msb, sum_msb, cout).
- One sub-module, addsub_nibble: a combinational 4-bit a + b + cin → sum, cout, c3 (carry into bit 3).
  - Instantiated exactly once.
  - The B inversion happens at latch time, not inside the slice.
- The nibble index counter is $clog2(NIB) bits wide and wraps to 0 on entry to RUN.

## Test plan
- Add, no carry: WIDTH=16, A=0x1234, B=0x0FED, sub=0 → res=0x2221, cout=0, ovf=0. out_valid is high exactly 4 cycles after the handshake.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1 → res=0xFFFE, cout=0, ovf=0. Then A=0x0007, B=0x0005 → 0x0002, cout=1.
- Signed overflow:
  - 0x7FFF+0x0001 → 0x8000, ovf=1, cout=0.
  - 0x8000−0x0001 → 0x7FFF, ovf=1, cout=1.
  - 0xFFFF+0x0001 → 0x0000, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and the results stay constant and in_ready stays 0. Raise out_ready → IDLE on the next edge, and a new handshake is accepted one edge later.
- Ignore and abort:
  - Toggle in_valid with different operands during RUN → result matches only the first request.
  - Pull rst_n low for 1 cycle during RUN → out_valid never rises for that request, and all outputs are 0 after the reset edge.
- Parameter sweep: WIDTH=8 and WIDTH=32 with random operands (≥1000 each) → results match a reference model, and latency equals NIB.
